// File: rtl/aes_pkg.sv
// Shared AES definitions: state width, forward S-box, init FSM states and
// byte/row/column index helpers for the column-major 128-bit state.
package aes_pkg;

    localparam int STATE_W = 128;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } init_state_e;

    // Forward S-box; element 0 is the leftmost byte of the literal.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Byte k of the state sits at row k%4, column k/4.
    function automatic int byte_idx(input int row, input int col);
        return row + 4 * col;
    endfunction

    function automatic int row_of(input int k);
        return k % 4;
    endfunction

    function automatic int col_of(input int k);
        return k / 4;
    endfunction

endpackage

// File: rtl/inv_sub_bytes.sv
// InvSubBytes: builds the inverse S-box at run time by walking the forward
// table, then performs 16 lookups spread evenly over SB_STAGES registers.
module inv_sub_bytes
    import aes_pkg::*;
#(
    parameter int SB_STAGES = 5
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [0:STATE_W-1] data_i,
    input  logic               vld_i,
    output logic [0:STATE_W-1] data_o,
    output logic               vld_o,
    output logic               ready_o
);

    init_state_e          state_q, state_d;
    logic [7:0]           idx_q, idx_d;
    logic                 tbl_we;
    logic [7:0]           inv_tbl [256];

    logic [0:STATE_W-1]   stage_in [SB_STAGES];
    logic [0:STATE_W-1]   data_d   [SB_STAGES];
    logic [0:STATE_W-1]   data_q   [SB_STAGES];
    logic [SB_STAGES-1:0] vld_q;
    logic [SB_STAGES-1:0] vld_in;

    // Init FSM state and table-walk index register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= INIT;
            idx_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next state: walk idx 0..255 once, then stay READY until reset.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            INIT: begin
                idx_d = idx_q + 8'd1;
                if (idx_q == 8'hff) begin
                    state_d = READY;
                end
            end
            READY:   state_d = READY;
            default: state_d = INIT;
        endcase
    end

    // FSM outputs: table write enable during INIT, ready flag in READY.
    always_comb begin
        tbl_we  = (state_q == INIT);
        ready_o = (state_q == READY);
    end

    // Inverse table fill; contents are fully rewritten after every reset.
    always_ff @(posedge clk_i) begin
        if (tbl_we) begin
            inv_tbl[SBOX[idx_q]] <= idx_q;
        end
    end

    // Lookup stages: byte k is substituted in stage (k*SB_STAGES)/16.
    always_comb begin
        stage_in[0] = data_i;
        for (int j = 1; j < SB_STAGES; j++) begin
            stage_in[j] = data_q[j-1];
        end
        vld_in = {vld_q[SB_STAGES-2:0], vld_i};
        for (int j = 0; j < SB_STAGES; j++) begin
            data_d[j] = stage_in[j];
            for (int k = 0; k < 16; k++) begin
                if ((k * SB_STAGES) / 16 == j) begin
                    data_d[j][8*k +: 8] = inv_tbl[stage_in[j][8*k +: 8]];
                end
            end
        end
    end

    // Pipeline registers; data only moves with a valid so the output holds.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            for (int j = 0; j < SB_STAGES; j++) begin
                data_q[j] <= '0;
            end
        end else begin
            vld_q <= vld_in;
            for (int j = 0; j < SB_STAGES; j++) begin
                if (vld_in[j]) begin
                    data_q[j] <= data_d[j];
                end
            end
        end
    end

    assign data_o = data_q[SB_STAGES-1];
    assign vld_o  = vld_q[SB_STAGES-1];

endmodule

// File: rtl/aes_inv_first_round.sv
// First AES-256 decryption round: AddRoundKey (key 14), InvShiftRows,
// then pipelined InvSubBytes. Blocks are accepted only once the inverse
// S-box table is ready; earlier blocks are dropped.
module aes_inv_first_round
    import aes_pkg::*;
#(
    parameter int SB_STAGES = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [0:STATE_W-1] in_data,
    input  logic               in_ready,
    input  logic [0:STATE_W-1] round_key,
    output logic [0:STATE_W-1] out_data,
    output logic               out_ready,
    output logic               s_box_ready
);

    logic               accept;
    logic [0:STATE_W-1] s1_q;
    logic               vld1_q;
    logic [0:STATE_W-1] s2_d;
    logic [0:STATE_W-1] s2_q;
    logic               vld2_q;

    assign accept = in_ready & s_box_ready;

    // Stage 1: AddRoundKey.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld1_q <= 1'b0;
            s1_q   <= '0;
        end else begin
            vld1_q <= accept;
            if (accept) begin
                s1_q <= in_data ^ round_key;
            end
        end
    end

    // InvShiftRows: out[r][c] = in[r][(c-r) mod 4], row r rotates right by r.
    always_comb begin
        s2_d = '0;
        for (int k = 0; k < 16; k++) begin
            s2_d[8*k +: 8] =
                s1_q[8*byte_idx(row_of(k), (col_of(k) - row_of(k) + 4) % 4) +: 8];
        end
    end

    // Stage 2: InvShiftRows register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld2_q <= 1'b0;
            s2_q   <= '0;
        end else begin
            vld2_q <= vld1_q;
            if (vld1_q) begin
                s2_q <= s2_d;
            end
        end
    end

    // Stage 3: InvSubBytes over SB_STAGES cycles, plus the init FSM.
    inv_sub_bytes #(
        .SB_STAGES(SB_STAGES)
    ) u_inv_sub_bytes (
        .clk_i   (clk),
        .rst_ni  (reset),
        .data_i  (s2_q),
        .vld_i   (vld2_q),
        .data_o  (out_data),
        .vld_o   (out_ready),
        .ready_o (s_box_ready)
    );

endmodule

// File: tb/tb_aes_inv_first_round.sv
// Bench for aes_inv_first_round: fixed vectors, random streams, early input
// during table init and mid-flight asynchronous reset.
module tb_aes_inv_first_round;

    localparam int SB  = 5;
    localparam int LAT = 2 + SB;

    logic         clk = 1'b0;
    logic         reset;
    logic [0:127] in_data;
    logic         in_ready;
    logic [0:127] round_key;
    logic [0:127] out_data;
    logic         out_ready;
    logic         s_box_ready;

    always #5 clk = ~clk;

    aes_inv_first_round #(.SB_STAGES(SB)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .round_key   (round_key),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .s_box_ready (s_box_ready)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference inverse S-box derived from GF(2^8) arithmetic.
    logic [7:0] ginv    [256];
    logic [7:0] inv_ref [256];

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            if (a[7]) a = (a << 1) ^ 8'h1b;
            else      a = a << 1;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_ref();
        logic [7:0] b;
        for (int a = 0; a < 256; a++) begin
            ginv[a] = 8'h00;
            for (int c = 1; c < 256; c++) begin
                if (gmul(8'(a), 8'(c)) == 8'h01) ginv[a] = 8'(c);
            end
        end
        for (int y = 0; y < 256; y++) begin
            b = rotl(8'(y), 1) ^ rotl(8'(y), 3) ^ rotl(8'(y), 6) ^ 8'h05;
            inv_ref[y] = ginv[b];
        end
    endtask

    function automatic logic [0:127] model(input logic [0:127] d, input logic [0:127] k);
        logic [0:127] x, res;
        logic [7:0]   st [4][4];
        x = d ^ k;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                st[r][c] = x[8*(4*c+r) +: 8];
        res = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                res[8*(4*c+r) +: 8] = inv_ref[st[r][(c - r + 4) % 4]];
        return res;
    endfunction

    task automatic chk128(input string name, input logic [0:127] act, input logic [0:127] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h required %h", name, act, exp);
        end
    endtask

    task automatic chkint(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name, act, exp);
        end
    endtask

    // Scoreboard: expected result and the cycle it must appear on.
    typedef struct {
        logic [0:127] d;
        int           due;
    } exp_t;

    exp_t         expq[$];
    exp_t         mon_e;
    logic         mon_on = 1'b0;
    int           popped = 0;
    logic [0:127] last_exp;

    always @(negedge clk) begin
        if (mon_on) begin
            if (expq.size() > 0 && cyc > expq[0].due) begin
                checks++;
                errors++;
                $display("FAIL missing_out got no out_ready required one at cycle %0d", expq[0].due);
                void'(expq.pop_front());
            end
            if (out_ready) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out got out_ready=1 data=%h required out_ready=0", out_data);
                end else begin
                    mon_e = expq.pop_front();
                    popped++;
                    chk128("out_data", out_data, mon_e.d);
                    chkint("latency_cycle", cyc, mon_e.due);
                end
            end
        end
    end

    task automatic send(input logic [0:127] d, input logic [0:127] k, input logic [0:127] e);
        exp_t x;
        in_data   = d;
        round_key = k;
        in_ready  = 1'b1;
        x.d       = e;
        x.due     = cyc + LAT;
        expq.push_back(x);
        last_exp  = e;
        @(negedge clk);
        in_ready  = 1'b0;
    endtask

    task automatic idle(input int n);
        in_ready = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Waits for s_box_ready after reset release; optionally drives one block
    // (which must be dropped) at cycle early_at. Returns -1 on timeout.
    task automatic wait_ready(input int early_at, output int rise);
        rise = -1;
        for (int k = 1; k <= 300; k++) begin
            if (k == early_at) begin
                in_data   = {$urandom, $urandom, $urandom, $urandom};
                round_key = {$urandom, $urandom, $urandom, $urandom};
                in_ready  = 1'b1;
            end else begin
                in_ready  = 1'b0;
            end
            @(negedge clk);
            if (s_box_ready) begin
                rise = k;
                break;
            end
        end
        in_ready = 1'b0;
    endtask

    typedef struct {
        logic [0:127] d;
        logic [0:127] k;
        logic [0:127] e;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #1ms;
        $display("FAIL watchdog got timeout required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int           rise;
        logic [0:127] rd, rk;
        int           base;

        build_ref();
        reset     = 1'b0;
        in_ready  = 1'b0;
        in_data   = '0;
        round_key = '0;
        repeat (3) @(negedge clk);

        chk128("reset_out_data", out_data, '0);
        chkint("reset_out_ready", int'(out_ready), 0);
        chkint("reset_s_box_ready", int'(s_box_ready), 0);

        // Init timing with a dropped block during INIT
        mon_on = 1'b1;
        reset  = 1'b1;
        wait_ready(100, rise);
        chkint("init_cycles", rise, 256);

        // Fixed and random single-block vectors
        vecs[0] = '{128'h8ea2b7ca516745bfeafc49904b496089,
                    128'h24fc79ccbf0979e9371ac23c6d68de36,
                    128'h627bceb9999d5aaac945ecf423f56da5};
        vecs[1] = '{128'h0, 128'h0, {16{8'h52}}};
        for (int i = 2; i < 6; i++) begin
            vecs[i].d = {$urandom, $urandom, $urandom, $urandom};
            vecs[i].k = {$urandom, $urandom, $urandom, $urandom};
            vecs[i].e = model(vecs[i].d, vecs[i].k);
        end
        for (int i = 0; i < 6; i++) begin
            send(vecs[i].d, vecs[i].k, vecs[i].e);
            idle(LAT + 3);
            chk128("hold_out_data", out_data, vecs[i].e);
            chkint("hold_out_ready", int'(out_ready), 0);
        end

        // 20 back-to-back random blocks
        base = popped;
        for (int i = 0; i < 20; i++) begin
            rd = {$urandom, $urandom, $urandom, $urandom};
            rk = {$urandom, $urandom, $urandom, $urandom};
            send(rd, rk, model(rd, rk));
        end
        idle(LAT + 3);
        chkint("stream_count", popped - base, 20);
        chk128("stream_hold", out_data, last_exp);

        // Random traffic with bubbles
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                rd = {$urandom, $urandom, $urandom, $urandom};
                rk = {$urandom, $urandom, $urandom, $urandom};
                send(rd, rk, model(rd, rk));
            end else begin
                idle(1);
            end
        end
        idle(LAT + 3);
        chkint("bubble_drained", expq.size(), 0);

        // Mid-flight asynchronous reset with three blocks in the pipe
        for (int i = 0; i < 3; i++) begin
            rd = {$urandom, $urandom, $urandom, $urandom};
            rk = {$urandom, $urandom, $urandom, $urandom};
            send(rd, rk, model(rd, rk));
        end
        #2;
        reset = 1'b0;
        #1;
        chk128("async_out_data", out_data, '0);
        chkint("async_out_ready", int'(out_ready), 0);
        chkint("async_s_box_ready", int'(s_box_ready), 0);
        expq.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        wait_ready(-1, rise);
        chkint("reinit_cycles", rise, 256);

        // Pipeline works again after re-init
        send(vecs[0].d, vecs[0].k, vecs[0].e);
        idle(LAT + 3);
        chkint("final_drained", expq.size(), 0);
        chk128("final_out_data", out_data, vecs[0].e);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
